// File: rtl/job_rx.sv
`default_nettype none
// ============================================================================
// Module   : job_rx
// Purpose  : Receives sync-framed, XOR-checksummed job frames from a UART
//            byte stream and publishes each accepted job atomically.
// Revision : 1.0 - initial release
// ============================================================================
module job_rx #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         JOB_BYTES = 80,
    parameter int         TIMEOUT   = 10000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_error,
    output logic [8*JOB_BYTES-1:0] job,
    output logic                   load,
    output logic                   busy,
    output logic                   bad_frame,
    output logic [7:0]             err_count
);

    localparam int c_CNT_W  = $clog2(JOB_BYTES + 1);
    localparam int c_IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0]  c_LAST_BYTE = c_CNT_W'(JOB_BYTES - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_PAYLOAD = 2'd1;
    localparam logic [1:0] c_CHECK   = 2'd2;

    logic [1:0]               r_state;
    logic [8*JOB_BYTES-1:0]   r_shadow;
    logic [7:0]               r_xor;
    logic [c_CNT_W-1:0]       r_count;
    logic [c_IDLE_W-1:0]      r_idle;

    logic w_in_frame;
    logic w_byte;
    logic w_timeout;
    logic w_abort;
    logic w_csum_bad;
    logic w_reject;

    // A framing error outranks a coincident byte, which is simply dropped.
    assign w_in_frame = (r_state != c_IDLE);
    assign w_byte     = rx_valid && !rx_error;
    assign w_timeout  = w_in_frame && !rx_valid && !rx_error && (r_idle == c_IDLE_LAST);
    assign w_abort    = (rx_error && w_in_frame) || w_timeout;
    assign w_csum_bad = w_byte && (r_state == c_CHECK) && (rx_byte != r_xor);
    assign w_reject   = w_abort || w_csum_bad;

    assign busy = w_in_frame;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_shadow  <= '0;
            r_xor     <= '0;
            r_count   <= '0;
            r_idle    <= '0;
            job       <= '0;
            load      <= 1'b0;
            bad_frame <= 1'b0;
            err_count <= '0;
        end else begin
            load      <= 1'b0;
            bad_frame <= 1'b0;

            if (w_reject) begin
                bad_frame <= 1'b1;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end

            // Inter-byte watchdog only runs while a frame is open.
            if (!w_in_frame || rx_valid) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end

            if (w_abort) begin
                r_state <= c_IDLE;
            end else if (w_byte) begin
                case (r_state)
                    c_IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            r_state <= c_PAYLOAD;
                            r_count <= '0;
                            r_xor   <= '0;
                        end
                    end
                    c_PAYLOAD: begin
                        r_shadow <= {r_shadow[8*JOB_BYTES-9:0], rx_byte};
                        r_xor    <= r_xor ^ rx_byte;
                        r_count  <= r_count + 1'b1;
                        if (r_count == c_LAST_BYTE) begin
                            r_state <= c_CHECK;
                        end
                    end
                    c_CHECK: begin
                        r_state <= c_IDLE;
                        if (rx_byte == r_xor) begin
                            job  <= r_shadow;
                            load <= 1'b1;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
